four_bit_divider: RTL and testbench
===================================

FOUR_BIT_DIVIDER -- requirements
Module: four_bit_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port A, input, 4 bits: unsigned dividend.
REQ-005 SHALL have port B, input, 4 bits: unsigned divisor.
REQ-006 SHALL have port Quot, output, 4 bits: registered quotient.
REQ-007 SHALL have port Rem, output, 4 bits: registered remainder.
REQ-008 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking valid Quot/Rem.
REQ-010 SHALL have port DivZero, output, 1 bit, present only when DIV_ZERO_CHECK_EN is defined: divisor was zero.

Function
REQ-011 SHALL implement a restoring shift-subtract divider producing one quotient bit per clock, MSB first.
REQ-012 SHALL use states IDLE, CALC, DONE; IDLE->CALC on the edge sampling start=1, CALC->DONE after the 4th iteration, DONE->IDLE after one cycle.
REQ-013 SHALL capture A and B into internal registers on the accepting edge; later changes to A/B SHALL NOT affect the operation in progress.
REQ-014 SHALL perform iterations on edges 1-4 after the accepting edge (edge 0); Quot/Rem SHALL be updated and done asserted after edge 4; done SHALL fall after edge 5.
REQ-015 SHALL assert busy from after edge 0 until done is asserted; busy and done SHALL never be high together.
REQ-016 SHALL ignore start while in CALC or DONE; no restart and no queued request.
REQ-017 SHALL hold Quot and Rem stable from done until the next completed operation; intermediate partial results SHALL NOT appear on Quot/Rem.
REQ-018 SHALL use a 5-bit partial remainder internally, so the subtract borrow is the restore decision; Rem SHALL always satisfy Rem < B for B != 0.
REQ-019 SHALL satisfy A = Quot*B + Rem for every B != 0.
REQ-020 SHALL treat start held high continuously as a new request each time IDLE is re-entered: back-to-back operations every 6 cycles.

Reset
REQ-021 SHALL, on rst_n=0, immediately force state IDLE, Quot=0, Rem=0, busy=0, done=0, DivZero=0, iteration counter=0, regardless of clk.
REQ-022 SHALL abandon any in-progress division on reset with no done pulse; after release the first rising edge with start=1 SHALL begin a fresh operation.

Configuration
REQ-023 SHALL, with DIV_ZERO_CHECK_EN defined and B=0 captured, skip CALC: after edge 1 Quot=4'b1111, Rem=A, DivZero=1, done=1 for one cycle; DivZero SHALL clear on the next accepted start.
REQ-024 SHALL, without DIV_ZERO_CHECK_EN, omit the DivZero port and run the normal 4-iteration algorithm for B=0, yielding Quot=4'b1111, Rem=A with standard latency.

Verification
REQ-025 A=13, B=3, start pulse -> after 4 edges done=1 for one cycle, Quot=4, Rem=1, busy high in between.
REQ-026 A=2, B=7 -> Quot=0, Rem=2; A=15, B=1 -> Quot=15, Rem=0.
REQ-027 A=9, B=0 -> with DIV_ZERO_CHECK_EN: done after edge 1, Quot=15, Rem=9, DivZero=1; without: done after edge 4, Quot=15, Rem=9.
REQ-028 Start 13/3, then assert start with A=6, B=2 during CALC -> result 4 rem 1 only; second request not executed.
REQ-029 rst_n low mid-CALC (after edge 2) -> Quot=0, Rem=0, busy=0, done never pulses; a subsequent 8/3 gives Quot=2, Rem=2.
REQ-030 Exhaustive sweep of all 256 A/B pairs, one operation each -> every B!=0 result matches A/B and A%B; every B=0 result matches REQ-023/REQ-024.

Source files
------------

// File: rtl/four_bit_divider_if.sv
// Handshake/data bundle for four_bit_divider.
// DivZero exists only when DIV_ZERO_CHECK_EN is defined.
interface four_bit_divider_if;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] Quot;
   logic [3:0] Rem;
   logic       busy;
   logic       done;
`ifdef DIV_ZERO_CHECK_EN
   logic       DivZero;
`endif

   modport master (
      output start, A, B,
      input  Quot, Rem, busy, done
`ifdef DIV_ZERO_CHECK_EN
      , input DivZero
`endif
   );

   modport slave (
      input  start, A, B,
      output Quot, Rem, busy, done
`ifdef DIV_ZERO_CHECK_EN
      , output DivZero
`endif
   );
endinterface

// File: rtl/four_bit_divider.sv
// Restoring 4-bit unsigned divider, one quotient bit per clock, MSB first.
// Optional divide-by-zero short cut and DivZero flag: define DIV_ZERO_CHECK_EN.
module four_bit_divider (
   input  logic                 clk,
   input  logic                 rst_n,
   four_bit_divider_if.slave    bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   // Upper nibble: restored partial remainder; lower nibble: dividend bits
   // shifting out at the top while quotient bits shift in at the bottom.
   logic [7:0] acc_q, acc_d;
   logic [3:0] b_q, b_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] quot_q, quot_d;
   logic [3:0] rem_q, rem_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
`ifdef DIV_ZERO_CHECK_EN
   logic       div_zero_q, div_zero_d;
`endif

   logic [4:0] part;
   logic       borrow;
   logic [3:0] diff;
   logic [3:0] rem_next;

   // 5-bit partial remainder; its borrow against B decides the restore.
   always_comb begin
      part     = acc_q[7:3];
      borrow   = (part < {1'b0, b_q});
      diff     = part[3:0] - b_q;
      rem_next = borrow ? part[3:0] : diff;
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      div_zero_d = div_zero_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = CALC;
               acc_d      = {4'd0, bus.A};
               b_d        = bus.B;
               cnt_d      = 2'd0;
               busy_d     = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
               div_zero_d = 1'b0;
`endif
            end
         end
         CALC: begin
`ifdef DIV_ZERO_CHECK_EN
            if (b_q == 4'd0) begin
               state_d    = DONE;
               quot_d     = 4'hF;
               rem_d      = acc_q[3:0];
               busy_d     = 1'b0;
               done_d     = 1'b1;
               div_zero_d = 1'b1;
            end else begin
`endif
               acc_d = {rem_next, acc_q[2:0], ~borrow};
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = DONE;
                  quot_d  = {acc_q[2:0], ~borrow};
                  rem_d   = rem_next;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
`ifdef DIV_ZERO_CHECK_EN
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_q      <= 8'd0;
         b_q        <= 4'd0;
         cnt_q      <= 2'd0;
         quot_q     <= 4'd0;
         rem_q      <= 4'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
         div_zero_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         b_q        <= b_d;
         cnt_q      <= cnt_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef DIV_ZERO_CHECK_EN
         div_zero_q <= div_zero_d;
`endif
      end
   end

   assign bus.Quot    = quot_q;
   assign bus.Rem     = rem_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
`ifdef DIV_ZERO_CHECK_EN
   assign bus.DivZero = div_zero_q;
`endif
endmodule

// File: tb/tb_four_bit_divider.sv
// Self-checking bench for four_bit_divider; honours DIV_ZERO_CHECK_EN.
module tb_four_bit_divider;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   four_bit_divider_if bus();
   four_bit_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [3:0] last_q = 4'd0;
   logic [3:0] last_r = 4'd0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int div_zero_out();
`ifdef DIV_ZERO_CHECK_EN
      return int'(bus.DivZero);
`else
      return 0;
`endif
   endfunction

   function automatic int model_q(input int a, input int b);
      return (b == 0) ? 15 : a / b;
   endfunction

   function automatic int model_r(input int a, input int b);
      return (b == 0) ? a : a % b;
   endfunction

   function automatic int model_lat(input int b);
`ifdef DIV_ZERO_CHECK_EN
      return (b == 0) ? 1 : 4;
`else
      return 4;
`endif
   endfunction

   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er);
      int lat;
      @(negedge clk);
      bus.A = a; bus.B = b; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.A = 4'($urandom);
      bus.B = 4'($urandom);
      chk("busy_after_accept", bus.busy, 1);
      chk("done_after_accept", bus.done, 0);
      lat = 0;
      while (!bus.done && lat < 10) begin
         chk("quot_stable", bus.Quot, last_q);
         chk("rem_stable", bus.Rem, last_r);
         @(posedge clk); #1;
         lat++;
         chk("busy_and_done", bus.busy & bus.done, 0);
      end
      chk("latency", lat, model_lat(b));
      chk("quot", bus.Quot, eq);
      chk("rem", bus.Rem, er);
      chk("busy_at_done", bus.busy, 0);
`ifdef DIV_ZERO_CHECK_EN
      chk("div_zero", div_zero_out(), int'(b == 4'd0));
`endif
      $display("op A=%0d B=%0d -> Quot=%0d Rem=%0d DivZero=%0d latency=%0d",
               a, b, bus.Quot, bus.Rem, div_zero_out(), lat);
      last_q = eq;
      last_r = er;
      @(posedge clk); #1;
      chk("done_fall", bus.done, 0);
      chk("busy_idle", bus.busy, 0);
   endtask

   initial begin
      int cnt;
      int pulses;
      logic [3:0] ra, rb;

      rst_n = 1'b0; bus.start = 1'b0; bus.A = 4'd0; bus.B = 4'd0;
      #12;
      chk("reset_quot", bus.Quot, 0);
      chk("reset_rem", bus.Rem, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_divzero", div_zero_out(), 0);
      @(negedge clk); rst_n = 1'b1;

      vecs[0] = '{a: 4'd13, b: 4'd3, q: 4'd4,  r: 4'd1};
      vecs[1] = '{a: 4'd2,  b: 4'd7, q: 4'd0,  r: 4'd2};
      vecs[2] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0};
      vecs[3] = '{a: 4'd9,  b: 4'd0, q: 4'd15, r: 4'd9};
      vecs[4] = '{a: 4'd0,  b: 4'd5, q: 4'd0,  r: 4'd0};
      vecs[5] = '{a: 4'd15, b: 4'd15, q: 4'd1, r: 4'd0};
      for (int i = 0; i < 6; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            run_op(4'(a), 4'(b), 4'(model_q(a, b)), 4'(model_r(a, b)));

      for (int i = 0; i < 30; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         run_op(ra, rb, 4'(model_q(ra, rb)), 4'(model_r(ra, rb)));
      end

      // start pulsed during CALC must be dropped, not queued
      @(negedge clk); bus.A = 4'd13; bus.B = 4'd3; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk); bus.A = 4'd6; bus.B = 4'd2; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      cnt = 0;
      while (!bus.done && cnt < 10) begin @(posedge clk); #1; cnt++; end
      chk("ignore_start_done_seen", bus.done, 1);
      chk("ignore_start_quot", bus.Quot, 4);
      chk("ignore_start_rem", bus.Rem, 1);
      @(posedge clk); #1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         pulses += int'(bus.done | bus.busy);
      end
      chk("no_queued_request", pulses, 0);
      $display("op A=13 B=3 with start during CALC -> Quot=%0d Rem=%0d", bus.Quot, bus.Rem);
      last_q = 4'd4; last_r = 4'd1;

      // reset mid-CALC abandons the operation
      @(negedge clk); bus.A = 4'd11; bus.B = 4'd2; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_quot", bus.Quot, 0);
      chk("midreset_rem", bus.Rem, 0);
      chk("midreset_busy", bus.busy, 0);
      chk("midreset_done", bus.done, 0);
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         pulses += int'(bus.done);
      end
      chk("no_done_after_reset", pulses, 0);
      $display("op A=11 B=2 aborted by reset -> Quot=%0d Rem=%0d", bus.Quot, bus.Rem);
      last_q = 4'd0; last_r = 4'd0;
      run_op(4'd8, 4'd3, 4'd2, 4'd2);

      // start held high: back-to-back operations every 6 cycles
      @(negedge clk); bus.A = 4'd13; bus.B = 4'd3; bus.start = 1'b1;
      cnt = 0;
      while (!bus.done && cnt < 12) begin @(posedge clk); #1; cnt++; end
      chk("b2b_first_done", bus.done, 1);
      chk("b2b_first_quot", bus.Quot, 4);
      cnt = 0;
      do begin @(posedge clk); #1; cnt++; end while (!bus.done && cnt < 12);
      chk("b2b_period", cnt, 6);
      chk("b2b_second_quot", bus.Quot, 4);
      chk("b2b_second_rem", bus.Rem, 1);
      $display("back-to-back A=13 B=3 -> period=%0d Quot=%0d Rem=%0d", cnt, bus.Quot, bus.Rem);
      @(negedge clk); bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_idle", bus.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
